// File: rtl/avm_sram_ctrl.sv
// Avalon-MM slave that runs each 32-bit request as one or two 16-bit cycles
// on an external asynchronous SRAM; writes are posted, reads return via readdatavalid.
module avm_sram_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [ADDR_WIDTH-1:0]   avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [DATA_WIDTH-1:0]   avs_writedata,
  input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
  output logic                    avs_waitrequest,
  output logic [DATA_WIDTH-1:0]   avs_readdata,
  output logic                    avs_readdatavalid,
  output logic [ADDR_WIDTH-2:0]   sram_addr,
  output logic [15:0]             sram_dq_o,
  output logic                    sram_dq_oe,
  input  logic [15:0]             sram_dq_i,
  output logic                    sram_ce_n,
  output logic                    sram_we_n,
  output logic                    sram_oe_n,
  output logic                    sram_ub_n,
  output logic                    sram_lb_n
);

  localparam int unsigned HALF_W  = 16;
  localparam int unsigned WADDR_W = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W   = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [WADDR_W-1:0]    waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic                  wr_q;

  logic                  accept;
  logic                  op_wr;
  logic [3:0]            op_be;
  logic [WADDR_W-1:0]    op_waddr;
  logic [DATA_WIDTH-1:0] op_wdata;

  logic [ADDR_WIDTH-2:0] sram_addr_d;
  logic [15:0]           sram_dq_o_d;
  logic                  sram_dq_oe_d;
  logic                  sram_ce_n_d, sram_we_n_d, sram_oe_n_d, sram_ub_n_d, sram_lb_n_d;
  logic [DATA_WIDTH-1:0] avs_readdata_d;
  logic                  avs_readdatavalid_d;
  logic                  in_phase, hi_phase;

  // Byte offset within the word is meaningless to a word-wide slave.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^avs_address[1:0];

  assign avs_waitrequest = (state != IDLE) || !HRESETn;
  assign accept          = (state == IDLE) && (avs_read || avs_write);

  // During the accept cycle the latches are still loading, so look through them.
  assign op_wr    = accept ? avs_write                          : wr_q;
  assign op_be    = accept ? avs_byteenable[3:0]                : be_q;
  assign op_waddr = accept ? avs_address[ADDR_WIDTH-1:2]        : waddr_q;
  assign op_wdata = accept ? avs_writedata                      : wdata_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Phase sequencing: LO for be[1:0], HI for be[3:2], RESP only for reads.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (|op_be[1:0])      state_d = LO;
          else if (|op_be[3:2]) state_d = HI;
          else                  state_d = op_wr ? IDLE : RESP;
        end
      end
      LO: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (|be_q[3:2]) state_d = HI;
          else            state_d = wr_q ? IDLE : RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HI: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          state_d = wr_q ? IDLE : RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so they can be registered
  // and still line up with the phase they belong to.
  always_comb begin
    in_phase            = (state_d == LO) || (state_d == HI);
    hi_phase            = (state_d == HI);
    sram_addr_d         = sram_addr;
    sram_dq_o_d         = sram_dq_o;
    sram_dq_oe_d        = 1'b0;
    sram_ce_n_d         = 1'b1;
    sram_we_n_d         = 1'b1;
    sram_oe_n_d         = 1'b1;
    sram_ub_n_d         = 1'b1;
    sram_lb_n_d         = 1'b1;
    avs_readdatavalid_d = (state_d == RESP);
    avs_readdata_d      = avs_readdata;

    if (in_phase) begin
      sram_addr_d = {op_waddr, hi_phase};
      sram_ce_n_d = 1'b0;
      sram_lb_n_d = hi_phase ? !op_be[2] : !op_be[0];
      sram_ub_n_d = hi_phase ? !op_be[3] : !op_be[1];
      if (op_wr) begin
        sram_dq_o_d  = hi_phase ? op_wdata[2*HALF_W-1:HALF_W] : op_wdata[HALF_W-1:0];
        sram_dq_oe_d = 1'b1;
        sram_we_n_d  = (cnt_d == CNT_LAST);
      end else begin
        sram_oe_n_d = 1'b0;
      end
    end

    // Read data is sampled on the edge that closes each half-word phase.
    if (accept) begin
      avs_readdata_d = '0;
    end else if (!wr_q && (cnt == CNT_LAST)) begin
      if (state == LO) avs_readdata_d[HALF_W-1:0]        = sram_dq_i;
      if (state == HI) avs_readdata_d[2*HALF_W-1:HALF_W] = sram_dq_i;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      waddr_q           <= '0;
      wdata_q           <= '0;
      be_q              <= '0;
      wr_q              <= 1'b0;
      sram_addr         <= '0;
      sram_dq_o         <= '0;
      sram_dq_oe        <= 1'b0;
      sram_ce_n         <= 1'b1;
      sram_we_n         <= 1'b1;
      sram_oe_n         <= 1'b1;
      sram_ub_n         <= 1'b1;
      sram_lb_n         <= 1'b1;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      if (accept) begin
        waddr_q <= op_waddr;
        wdata_q <= op_wdata;
        be_q    <= op_be;
        wr_q    <= op_wr;
      end
      sram_addr         <= sram_addr_d;
      sram_dq_o         <= sram_dq_o_d;
      sram_dq_oe        <= sram_dq_oe_d;
      sram_ce_n         <= sram_ce_n_d;
      sram_we_n         <= sram_we_n_d;
      sram_oe_n         <= sram_oe_n_d;
      sram_ub_n         <= sram_ub_n_d;
      sram_lb_n         <= sram_lb_n_d;
      avs_readdata      <= avs_readdata_d;
      avs_readdatavalid <= avs_readdatavalid_d;
    end
  end

endmodule
